div_unit: RTL and testbench



---
 rtl/calc_pkg.sv | 19 +
 rtl/div_step.sv | 32 +++
 rtl/div_unit.sv | 133 +++++++++++++
 tb/tb_div_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator datapath.
//   WIDTH        operand width of the arithmetic paths
//   CMD_SUB      Command code of the existing subtract operation
//   CMD_DIV      Command code that selects the sequential divider
//   div_state_e  divider controller states
package calc_pkg;

  localparam int WIDTH = 16;

  localparam logic [3:0] CMD_SUB = 4'd3;
  localparam logic [3:0] CMD_DIV = 4'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one iteration of restoring division (purely combinational).
//   rem_in        partial remainder before this iteration
//   dividend_bit  next dividend bit shifted into the remainder
//   divisor       divisor
//   rem_out       partial remainder after this iteration
//   quo_bit       quotient bit produced by this iteration
module div_step
  import calc_pkg::*;
(
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             quo_bit
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;
  logic             unused_rem_msb;

  // The remainder before the k-th shift is below 2^(k-1), so its MSB is
  // always zero on entry and dropping it in the shift loses nothing.
  assign unused_rem_msb = rem_in[WIDTH-1];
  assign shifted        = {rem_in[WIDTH-2:0], dividend_bit};

  // Subtract as invert-plus-carry-in on a 17-bit word; bit 16 set means
  // the result went negative (borrow), so the old value is restored.
  assign trial   = {1'b0, shifted} + {1'b1, ~divisor} + {{WIDTH{1'b0}}, 1'b1};
  assign quo_bit = ~trial[WIDTH];
  assign rem_out = quo_bit ? trial[WIDTH-1:0] : shifted;

endmodule

// File: rtl/div_unit.sv
// div_unit: sequential 16-bit unsigned restoring divider.
//   clk, rst_n  clock and asynchronous active-low reset
//   start       request, honoured in IDLE when Command == CMD_DIV
//   Command     operation code
//   inputP      dividend
//   inputQ      divisor
//   busy        high while iterating
//   done        one-cycle pulse when S/E have been updated
//   S           {remainder, quotient}
//   E           divide-by-zero flag of the last accepted operation
module div_unit
  import calc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         Command,
  input  logic [WIDTH-1:0]   inputP,
  input  logic [WIDTH-1:0]   inputQ,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] S,
  output logic               E
);

  div_state_e         state_q, state_d;
  logic [3:0]         count_q, count_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [2*WIDTH-1:0] s_q, s_d;
  logic               e_q, e_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   step_rem;
  logic               step_bit;

  // quo_q doubles as the dividend shift register: its MSB feeds the
  // iteration while quotient bits enter from the bottom.
  div_step u_step (
    .rem_in       (rem_q),
    .dividend_bit (quo_q[WIDTH-1]),
    .divisor      (dvsr_q),
    .rem_out      (step_rem),
    .quo_bit      (step_bit)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    s_d     = s_q;
    e_d     = e_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && (Command == CMD_DIV)) begin
          if (inputQ == '0) begin
            // Divide by zero completes at once: remainder = dividend,
            // quotient saturates to all ones.
            s_d     = {inputP, {WIDTH{1'b1}}};
            e_d     = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            quo_d   = inputP;
            dvsr_d  = inputQ;
            rem_d   = '0;
            count_d = '0;
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        rem_d   = step_rem;
        quo_d   = {quo_q[WIDTH-2:0], step_bit};
        count_d = count_q + 4'd1;
        if (count_q == 4'(WIDTH - 1)) begin
          s_d     = {step_rem, quo_q[WIDTH-2:0], step_bit};
          e_d     = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      s_q     <= '0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      s_q     <= s_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign E    = e_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and small randomized checks of div_unit, including
// cycle-exact busy/done timing, ignored starts and mid-operation reset.
module tb_div_unit;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start;
  logic [3:0]  Command;
  logic [15:0] inputP;
  logic [15:0] inputQ;
  logic        busy;
  logic        done;
  logic [31:0] S;
  logic        E;

  int checkCount = 0;
  int errorCount = 0;

  div_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .Command (Command),
    .inputP  (inputP),
    .inputQ  (inputQ),
    .busy    (busy),
    .done    (done),
    .S       (S),
    .E       (E)
  );

  // 10 time-unit clock; rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Every comparison goes through here so the counts stay consistent.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge so outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one start request for exactly one edge.
  task automatic applyStimulus(input logic [3:0] cmd, input logic [15:0] p,
                               input logic [15:0] q);
    start   = 1'b1;
    Command = cmd;
    inputP  = p;
    inputQ  = q;
    tick();
    start   = 1'b0;
  endtask

  // Run one division and check result, flag, latency, busy length and the
  // single-cycle done pulse. With noisy set, start is held high with junk
  // operands and alternating commands while the division runs.
  task automatic runDivision(input string tag, input logic [15:0] p,
                             input logic [15:0] q, input bit noisy);
    logic [31:0] expS;
    logic        expE;
    int          expLat;
    int          expBusy;
    int          cycles;
    int          busyCnt;
    if (q == 16'd0) begin
      expS    = {p, 16'hFFFF};
      expE    = 1'b1;
      expLat  = 0;
      expBusy = 0;
    end else begin
      expS    = {p % q, p / q};
      expE    = 1'b0;
      expLat  = 16;
      expBusy = 16;
    end
    applyStimulus(CMD_DIV, p, q);
    busyCnt = busy ? 1 : 0;
    cycles  = 0;
    while (!done && cycles < 40) begin
      if (noisy) begin
        start   = 1'b1;
        Command = cycles[0] ? CMD_SUB : CMD_DIV;
        inputP  = 16'($urandom);
        inputQ  = 16'($urandom);
      end
      tick();
      cycles++;
      if (busy) busyCnt++;
    end
    start = 1'b0;
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(expLat));
    checkOutput({tag, "_busy_cycles"}, 32'(busyCnt), 32'(expBusy));
    checkOutput({tag, "_S"}, S, expS);
    checkOutput({tag, "_E"}, 32'(E), 32'(expE));
    tick();
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int doneSeen;
    logic [15:0] rp;
    logic [15:0] rq;

    start   = 1'b0;
    Command = 4'd0;
    inputP  = 16'd0;
    inputQ  = 16'd0;

    // Reset state, asserted off the clock edge.
    #2 rst_n = 1'b0;
    #10;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_S", S, 32'd0);
    checkOutput("reset_E", 32'(E), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic and boundary operands.
    runDivision("d100_7", 16'd100, 16'd7, 1'b0);
    checkOutput("d100_7_const", S, 32'h0002_000E);
    runDivision("dFFFF_1", 16'hFFFF, 16'h0001, 1'b0);
    checkOutput("dFFFF_1_const", S, 32'h0000_FFFF);
    runDivision("d3_FFFF", 16'h0003, 16'hFFFF, 1'b0);
    checkOutput("d3_FFFF_const", S, 32'h0003_0000);

    // Divide by zero, then a normal division clears E.
    runDivision("d5_0", 16'd5, 16'd0, 1'b0);
    checkOutput("d5_0_const", S, 32'h0005_FFFF);
    runDivision("d9_3", 16'd9, 16'd3, 1'b0);
    checkOutput("d9_3_const", S, 32'h0000_0003);

    // A start with the subtract code must leave everything untouched.
    applyStimulus(CMD_SUB, 16'd50, 16'd5);
    checkOutput("cmdsub_busy", 32'(busy), 32'd0);
    checkOutput("cmdsub_done", 32'(done), 32'd0);
    tick();
    tick();
    checkOutput("cmdsub_S_hold", S, 32'h0000_0003);
    checkOutput("cmdsub_E_hold", 32'(E), 32'd0);

    // Starts during RUN with other operands do not disturb the result.
    runDivision("noisy100_7", 16'd100, 16'd7, 1'b1);
    runDivision("noisyFFFF_FF", 16'hFFFF, 16'h00FF, 1'b1);

    // Reset in the middle of RUN discards the operation immediately.
    applyStimulus(CMD_DIV, 16'd1234, 16'd5);
    repeat (8) tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_S", S, 32'd0);
    checkOutput("midrst_E", 32'(E), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) doneSeen++;
    end
    checkOutput("midrst_no_done", 32'(doneSeen), 32'd0);
    runDivision("d1000_10", 16'd1000, 16'd10, 1'b0);
    checkOutput("d1000_10_const", S, 32'h0000_0064);

    // Randomized operands against the behavioural quotient/remainder.
    for (int n = 0; n < 400; n++) begin
      rp = 16'($urandom);
      if ($urandom_range(99) == 0)
        rq = 16'd0;
      else if ($urandom_range(3) == 0)
        rq = 16'($urandom_range(1, 255));
      else
        rq = 16'($urandom);
      runDivision("rand", rp, rq, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
